// File: rtl/bcd_div11_seq.sv
// rtl/bcd_div11_seq.sv - digit-serial divisible-by-11 checker for a packed BCD word
// Shifts the captured word MS-digit first through a mod-11 accumulator, one digit per clock.
module bcd_div11_seq #(
    parameter int N_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*N_DIGITS-1:0]   din,
    output logic                    busy,
    output logic                    done,
    output logic                    divisible,
    output logic [3:0]              remainder,
    output logic                    invalid
);

    localparam int W = 4 * N_DIGITS;
    localparam logic [2:0] LAST_CNT = 3'(N_DIGITS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [W-1:0] sh_q, sh_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [3:0]   acc_q, acc_d;
    logic         err_q, err_d;
    logic         done_q, done_d;
    logic         div_q, div_d;
    logic [3:0]   rem_q, rem_d;
    logic         inv_q, inv_d;

    logic [3:0]   digit;
    logic [3:0]   diff;
    logic [3:0]   acc_next;
    logic         err_next;

    assign digit = sh_q[W-1 -: 4];

    // Horner step with 10 == -1 (mod 11): acc' = d - acc, folded into 0..10.
    // The 4-bit wrap is exact here because the true result never exceeds 10 for legal digits.
    assign diff     = digit - acc_q;
    assign acc_next = (digit >= acc_q) ? diff : diff + 4'd11;
    assign err_next = err_q | (digit > 4'd9);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        err_d   = err_q;
        done_d  = 1'b0;
        div_d   = div_q;
        rem_d   = rem_q;
        inv_d   = inv_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh_d    = din;
                    cnt_d   = 3'd0;
                    acc_d   = 4'd0;
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sh_d  = sh_q << 4;
                acc_d = acc_next;
                err_d = err_next;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    inv_d   = err_next;
                    rem_d   = err_next ? 4'd0 : acc_next;
                    div_d   = !err_next && (acc_next == 4'd0);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= 3'd0;
            acc_q   <= 4'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            div_q   <= 1'b0;
            rem_q   <= 4'd0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            done_q  <= done_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            inv_q   <= inv_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign divisible = div_q;
    assign remainder = rem_q;
    assign invalid   = inv_q;

endmodule

// File: tb/tb_bcd_div11_seq.sv
// tb/tb_bcd_div11_seq.sv - scoreboard bench for bcd_div11_seq
module tb_bcd_div11_seq;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] din = 16'h0;
    logic        busy;
    logic        done;
    logic        divisible;
    logic [3:0]  remainder;
    logic        invalid;

    int tests_run = 0;
    int failures  = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic        div;
        logic [3:0]  rem;
        logic        inv;
        logic        bsy;
        int unsigned cyc;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];

    bcd_div11_seq #(.N_DIGITS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .din       (din),
        .busy      (busy),
        .done      (done),
        .divisible (divisible),
        .remainder (remainder),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            res_t r;
            r.div = divisible;
            r.rem = remainder;
            r.inv = invalid;
            r.bsy = busy;
            r.cyc = cyc;
            obs_q.push_back(r);
        end
    end

    // Reference: true decimal value reduced mod 11, independent of the digit recurrence.
    function automatic res_t model(input logic [15:0] w);
        res_t r;
        int v;
        logic [3:0] nib;
        v = 0;
        r.inv = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            nib = w[4*i +: 4];
            if (nib > 4'd9) r.inv = 1'b1;
            v = v * 10 + int'(nib);
        end
        r.rem = r.inv ? 4'd0 : 4'(v % 11);
        r.div = !r.inv && (v % 11 == 0);
        r.bsy = 1'b0;
        r.cyc = 0;
        return r;
    endfunction

    task automatic issue_start(input logic [15:0] w, output int unsigned t0);
        @(negedge clk);
        start = 1'b1;
        din   = w;
        exp_q.push_back(model(w));
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_obs(input int want, output bit ok);
        for (int k = 0; k < 60 && obs_q.size() < want; k++) @(negedge clk);
        ok = (obs_q.size() >= want);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, divisible, remainder, invalid} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b div=%b rem=%0d inv=%b, want all 0",
                     busy, done, divisible, remainder, invalid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [15:0] words [9] = '{16'h7777, 16'h2121, 16'h5000, 16'h0000, 16'h9240,
                                   16'h9999, 16'h0909, 16'h12A4, 16'h0704};
        logic prev_div;
        int unsigned t0;
        bit ok;
        res_t o, e;
        prev_div = 1'b0;
        foreach (words[i]) begin
            issue_start(words[i], t0);
            tests_run++;
            if (busy !== 1'b1 || divisible !== prev_div) begin
                failures++;
                $display("FAIL basic_start_%h: got busy=%b div=%b, want busy=1 div=%b",
                         words[i], busy, divisible, prev_div);
            end
            wait_obs(1, ok);
            tests_run++;
            if (!ok) begin
                failures++;
                $display("FAIL basic_timeout_%h: got no done, want done", words[i]);
                void'(exp_q.pop_front());
            end else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                if (o.div !== e.div || o.rem !== e.rem || o.inv !== e.inv ||
                    o.bsy !== 1'b0 || (o.cyc - t0) != N) begin
                    failures++;
                    $display("FAIL basic_%h: got div=%b rem=%0d inv=%b busy=%b lat=%0d, want div=%b rem=%0d inv=%b busy=0 lat=%0d",
                             words[i], o.div, o.rem, o.inv, o.bsy, o.cyc - t0, e.div, e.rem, e.inv, N);
                end
                prev_div = e.div;
            end
        end
    endtask

    task automatic test_ignore_busy();
        int unsigned t0;
        bit ok;
        res_t o, e;
        issue_start(16'h8272, t0);
        start = 1'b1;
        din   = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        wait_obs(1, ok);
        tests_run++;
        if (!ok) begin
            failures++;
            $display("FAIL ignore_busy_timeout: got no done, want done");
            void'(exp_q.pop_front());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.div !== e.div || o.rem !== e.rem || o.inv !== e.inv || (o.cyc - t0) != N) begin
                failures++;
                $display("FAIL ignore_busy_result: got div=%b rem=%0d inv=%b lat=%0d, want div=%b rem=%0d inv=%b lat=%0d",
                         o.div, o.rem, o.inv, o.cyc - t0, e.div, e.rem, e.inv, N);
            end
        end
        repeat (8) @(negedge clk);
        tests_run++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_busy_extra: got %0d extra done busy=%b, want 0 busy=0", obs_q.size(), busy);
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3] = '{16'h9240, 16'h2121, 16'h1234};
        int n;
        res_t o [3];
        res_t e;
        @(negedge clk);
        start = 1'b1;
        din   = words[0];
        exp_q.push_back(model(words[0]));
        n = 0;
        for (int k = 0; k < 60 && n < 3; k++) begin
            @(negedge clk);
            if (done) begin
                n++;
                if (n < 3) begin
                    din = words[n];
                    exp_q.push_back(model(words[n]));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (n != 3 || obs_q.size() < 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d done, want 3", n);
            obs_q.delete();
            exp_q.delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                o[i] = obs_q.pop_front();
                e    = exp_q.pop_front();
                tests_run++;
                if (o[i].div !== e.div || o[i].rem !== e.rem || o[i].inv !== e.inv) begin
                    failures++;
                    $display("FAIL b2b_result_%0d: got div=%b rem=%0d inv=%b, want div=%b rem=%0d inv=%b",
                             i, o[i].div, o[i].rem, o[i].inv, e.div, e.rem, e.inv);
                end
                if (i > 0) begin
                    tests_run++;
                    if (o[i].cyc - o[i-1].cyc != N + 1) begin
                        failures++;
                        $display("FAIL b2b_period_%0d: got %0d, want %0d", i, o[i].cyc - o[i-1].cyc, N + 1);
                    end
                end
            end
        end
        repeat (8) @(negedge clk);
        tests_run++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_extra: got %0d extra done, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_run();
        int unsigned t0;
        bit ok;
        res_t o, e;
        issue_start(16'h9119, t0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, divisible, remainder, invalid} !== 8'h00) begin
            failures++;
            $display("FAIL midrun_reset: got busy=%b done=%b div=%b rem=%0d inv=%b, want all 0",
                     busy, done, divisible, remainder, invalid);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        tests_run++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_done: got %0d done busy=%b, want 0 busy=0", obs_q.size(), busy);
            obs_q.delete();
        end
        issue_start(16'h9119, t0);
        wait_obs(1, ok);
        tests_run++;
        if (!ok) begin
            failures++;
            $display("FAIL midrun_restart_timeout: got no done, want done");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o.div !== e.div || o.rem !== e.rem || o.inv !== e.inv || (o.cyc - t0) != N) begin
                failures++;
                $display("FAIL midrun_restart: got div=%b rem=%0d inv=%b lat=%0d, want div=%b rem=%0d inv=%b lat=%0d",
                         o.div, o.rem, o.inv, o.cyc - t0, e.div, e.rem, e.inv, N);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
